// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint.
package i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 7;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StRx,
      StRxAck,
      StTx,
      StTxAck,
      StIgnore
   } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus glitch filter for one I2C pad input, with filtered edge pulses.
module i2c_line_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   // The tail of the synchroniser chain doubles as the filter window.
   localparam int unsigned ChainLen = SYNC_STAGES + FILTER_LEN - 1;

   logic [ChainLen-1:0]   chain_q;
   logic [FILTER_LEN-1:0] win;
   logic                  all_hi, all_lo;
   logic                  level_q, rise_q, fall_q;

   assign win    = chain_q[ChainLen-1 -: FILTER_LEN];
   assign all_hi = &win;
   assign all_lo = ~|win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '1;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         chain_q <= {chain_q[ChainLen-2:0], line_i};
         rise_q  <= all_hi & ~level_q;
         fall_q  <= all_lo & level_q;
         if (all_hi) begin
            level_q <= 1'b1;
         end else if (all_lo) begin
            level_q <= 1'b0;
         end
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: START/STOP detection, address match, byte receive and transmit.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
   parameter int unsigned           SYNC_STAGES = 2,
   parameter int unsigned           FILTER_LEN  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_req_o,
   output logic       busy_o,
   output logic       rw_o,
   output logic       start_det_o,
   output logic       stop_det_o
);

   logic scl_f, scl_rise, scl_fall;
   logic sda_f, sda_rise, sda_fall;
   logic start_cond, stop_cond;
   logic [7:0] byte_in;

   i2c_tgt_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
   logic ack_q, ack_d, sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
   logic busy_q, busy_d, rw_q, rw_d, start_det_q, start_det_d, stop_det_q, stop_det_d;

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (scl_i),
      .level_o(scl_f),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (sda_i),
      .level_o(sda_f),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   // An SCL rise in the same filtered cycle wins: that SDA change is a data bit.
   assign start_cond = sda_fall & scl_f & ~scl_rise;
   assign stop_cond  = sda_rise & scl_f & ~scl_rise;
   assign byte_in    = {shift_q[6:0], sda_f};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      ack_d       = ack_q;
      sda_oe_d    = sda_oe_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_req_d    = 1'b0;
      busy_d      = busy_q;
      rw_d        = rw_q;
      start_det_d = 1'b0;
      stop_det_d  = 1'b0;
      if (stop_cond) begin
         state_d    = StIdle;
         cnt_d      = '0;
         busy_d     = 1'b0;
         sda_oe_d   = 1'b0;
         stop_det_d = 1'b1;
      end else if (start_cond) begin
         state_d     = StAddr;
         cnt_d       = '0;
         busy_d      = 1'b0;
         sda_oe_d    = 1'b0;
         start_det_d = 1'b1;
      end else begin
         unique case (state_q)
            StIdle, StIgnore: sda_oe_d = 1'b0;
            StAddr: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     if (byte_in[7:1] == TARGET_ADDR && TARGET_ADDR != '0) begin
                        rw_d    = byte_in[0];
                        busy_d  = 1'b1;
                        state_d = StAddrAck;
                     end else begin
                        state_d = StIgnore;
                     end
                  end
               end
            end
            StAddrAck: begin
               if (tx_req_q) shift_d = tx_data_i;
               if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = 1'b1;
                     cnt_d    = 4'd9;
                     tx_req_d = rw_q;
                  end else begin
                     cnt_d = '0;
                     if (rw_q) begin
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                        state_d  = StTx;
                     end else begin
                        sda_oe_d = 1'b0;
                        state_d  = StRx;
                     end
                  end
               end
            end
            StRx: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     ack_d   = rx_ready_i;
                     state_d = StRxAck;
                     if (rx_ready_i) begin
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                     end
                  end
               end
            end
            StRxAck: begin
               if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = ack_q;
                     cnt_d    = 4'd9;
                  end else begin
                     sda_oe_d = 1'b0;
                     cnt_d    = '0;
                     state_d  = StRx;
                  end
               end
            end
            StTx: begin
               // Follow-on bytes arrive one cycle after the ACK fall; drive their MSB on load.
               if (tx_req_q) begin
                  shift_d  = {tx_data_i[6:0], 1'b0};
                  sda_oe_d = ~tx_data_i[7];
               end else if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = StTxAck;
                  end else begin
                     sda_oe_d = ~shift_q[7];
                     shift_d  = {shift_q[6:0], 1'b0};
                  end
               end
            end
            StTxAck: begin
               if (scl_rise) begin
                  ack_d = ~sda_f;
                  cnt_d = 4'd9;
               end else if (scl_fall && cnt_q == 4'd9) begin
                  cnt_d = '0;
                  if (ack_q) begin
                     tx_req_d = 1'b1;
                     state_d  = StTx;
                  end else begin
                     state_d = StIgnore;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         shift_q     <= '0;
         ack_q       <= 1'b0;
         sda_oe_q    <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_req_q    <= 1'b0;
         busy_q      <= 1'b0;
         rw_q        <= 1'b0;
         start_det_q <= 1'b0;
         stop_det_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         ack_q       <= ack_d;
         sda_oe_q    <= sda_oe_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_req_q    <= tx_req_d;
         busy_q      <= busy_d;
         rw_q        <= rw_d;
         start_det_q <= start_det_d;
         stop_det_q  <= stop_det_d;
      end
   end

   assign sda_oe_o    = sda_oe_q;
   assign rx_data_o   = rx_data_q;
   assign rx_valid_o  = rx_valid_q;
   assign tx_req_o    = tx_req_q;
   assign busy_o      = busy_q;
   assign rw_o        = rw_q;
   assign start_det_o = start_det_q;
   assign stop_det_o  = stop_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged initiator plus rx/tx byte scoreboards.
module tb_i2c_target;

   localparam int unsigned Q = 10;  // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_line;
   logic       rx_ready = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       sda_oe, rx_valid, tx_req, busy, rw, start_det, stop_det;
   logic [7:0] rx_data;

   int checks = 0;
   int failures = 0;
   int n_rx = 0, n_tx = 0, n_start = 0, n_stop = 0;
   bit oe_seen = 1'b0;
   logic [7:0] exp_rx_q[$];
   logic [7:0] tx_src_q[$];
   logic [7:0] mon_exp;

   assign sda_line = sda_drv & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl_i      (scl_drv),
      .sda_i      (sda_line),
      .sda_oe_o   (sda_oe),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .rx_ready_i (rx_ready),
      .tx_data_i  (tx_data),
      .tx_req_o   (tx_req),
      .busy_o     (busy),
      .rw_o       (rw),
      .start_det_o(start_det),
      .stop_det_o (stop_det)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            n_rx++;
            checks++;
            if (exp_rx_q.size() == 0) begin
               failures++;
               $display("FAIL rx_scoreboard: rx_valid with rx_data=%h, required no rx_valid", rx_data);
            end else begin
               mon_exp = exp_rx_q.pop_front();
               if (rx_data !== mon_exp) begin
                  failures++;
                  $display("FAIL rx_scoreboard: rx_data=%h, required %h", rx_data, mon_exp);
               end
            end
         end
         if (tx_req) begin
            n_tx++;
            if (tx_src_q.size() > 0) tx_data = tx_src_q.pop_front();
         end
         if (start_det) n_start++;
         if (stop_det) n_stop++;
         if (sda_oe) oe_seen = 1'b1;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_drv = 1'b1;
      scl_drv = 1'b1;
      wait_clk(Q);
      sda_drv = 1'b0;
      wait_clk(2 * Q);
      scl_drv = 1'b0;
   endtask

   task automatic bus_rstart();
      wait_clk(Q);
      sda_drv = 1'b1;
      wait_clk(Q);
      scl_drv = 1'b1;
      wait_clk(2 * Q);
      sda_drv = 1'b0;
      wait_clk(2 * Q);
      scl_drv = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(Q);
      sda_drv = 1'b0;
      wait_clk(Q);
      scl_drv = 1'b1;
      wait_clk(2 * Q);
      sda_drv = 1'b1;
      wait_clk(2 * Q);
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      wait_clk(Q);
      sda_drv = b;
      wait_clk(Q);
      scl_drv = 1'b1;
      wait_clk(Q);
      s = sda_line;
      wait_clk(Q);
      scl_drv = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
      bit_xfer(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(~ack, s);
   endtask

   task automatic test_reset();
      wait_clk(3);
      checks += 4;
      if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe: got %b, required 0", sda_oe); end
      if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
      if ({rx_valid, tx_req, busy, rw} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got valid/req/busy/rw=%b, required 0000", {rx_valid, tx_req, busy, rw});
      end
      if ({start_det, stop_det} !== 2'b00) begin
         failures++;
         $display("FAIL reset_det: got %b, required 00", {start_det, stop_det});
      end
      rst_n = 1'b1;
      wait_clk(4 * Q);
      checks++;
      if (n_start != 0 || n_stop != 0) begin
         failures++;
         $display("FAIL reset_release_det: got start=%0d stop=%0d, required 0 0", n_start, n_stop);
      end
   endtask

   task automatic test_write();
      logic a0, a1;
      int rx0, st0, sp0;
      rx0 = n_rx; st0 = n_start; sp0 = n_stop;
      rx_ready = 1'b1;
      bus_start();
      write_byte(8'h84, a0);
      checks += 2;
      if (a0 !== 1'b1) begin failures++; $display("FAIL write_addr_ack: got %b, required 1", a0); end
      if ({busy, rw} !== 2'b10) begin failures++; $display("FAIL write_busy_rw: got %b, required 10", {busy, rw}); end
      exp_rx_q.push_back(8'hA5);
      write_byte(8'hA5, a1);
      bus_stop();
      checks += 5;
      if (a1 !== 1'b1) begin failures++; $display("FAIL write_data_ack: got %b, required 1", a1); end
      if (n_rx - rx0 != 1) begin failures++; $display("FAIL write_rx_count: got %0d, required 1", n_rx - rx0); end
      if (rx_data !== 8'hA5) begin failures++; $display("FAIL write_rx_data: got %h, required a5", rx_data); end
      if (n_start - st0 != 1 || n_stop - sp0 != 1) begin
         failures++;
         $display("FAIL write_start_stop: got %0d/%0d, required 1/1", n_start - st0, n_stop - sp0);
      end
      if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_end: got %b, required 0", busy); end
   endtask

   task automatic test_read();
      logic a0;
      logic [7:0] d0, d1;
      int tx0;
      tx0 = n_tx;
      tx_src_q.push_back(8'h3C);
      tx_src_q.push_back(8'hC3);
      bus_start();
      write_byte(8'h85, a0);
      read_byte(1'b1, d0);
      read_byte(1'b0, d1);
      checks += 6;
      if (a0 !== 1'b1 || rw !== 1'b1) begin
         failures++;
         $display("FAIL read_addr: got ack=%b rw=%b, required 1 1", a0, rw);
      end
      if (d0 !== 8'h3C) begin failures++; $display("FAIL read_byte0: got %h, required 3c", d0); end
      if (d1 !== 8'hC3) begin failures++; $display("FAIL read_byte1: got %h, required c3", d1); end
      if (n_tx - tx0 != 2) begin failures++; $display("FAIL read_tx_req: got %0d, required 2", n_tx - tx0); end
      if (sda_oe !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL read_ignore: got oe=%b busy=%b, required 0 1", sda_oe, busy);
      end
      bus_stop();
      if (busy !== 1'b0) begin failures++; $display("FAIL read_stop_busy: got %b, required 0", busy); end
   endtask

   task automatic test_addr_miss();
      logic a0;
      int rx0, tx0;
      rx0 = n_rx; tx0 = n_tx;
      oe_seen = 1'b0;
      bus_start();
      write_byte(8'h86, a0);
      write_byte(8'h55, a0);
      checks += 3;
      if (oe_seen !== 1'b0) begin failures++; $display("FAIL miss_sda_oe: got asserted, required never"); end
      if (busy !== 1'b0) begin failures++; $display("FAIL miss_busy: got %b, required 0", busy); end
      if (n_rx != rx0 || n_tx != tx0) begin
         failures++;
         $display("FAIL miss_rx_tx: got %0d/%0d, required 0/0", n_rx - rx0, n_tx - tx0);
      end
      bus_stop();
   endtask

   task automatic test_backpressure();
      logic a0, a1;
      int rx0;
      rx0 = n_rx;
      bus_start();
      write_byte(8'h84, a0);
      rx_ready = 1'b0;
      write_byte(8'h11, a1);
      rx_ready = 1'b1;
      checks += 3;
      if (a0 !== 1'b1 || a1 !== 1'b0) begin
         failures++;
         $display("FAIL bp_ack: got addr=%b data=%b, required 1 0", a0, a1);
      end
      if (n_rx != rx0) begin failures++; $display("FAIL bp_rx_valid: got %0d, required 0", n_rx - rx0); end
      if (rx_data !== 8'hA5) begin failures++; $display("FAIL bp_rx_data: got %h, required a5", rx_data); end
      bus_stop();
   endtask

   task automatic test_back_to_back();
      logic a0, a1, a2;
      logic rw0;
      logic [7:0] d0;
      int rx0, tx0, st0;
      rx0 = n_rx; tx0 = n_tx; st0 = n_start;
      tx_src_q.push_back(8'h99);
      exp_rx_q.push_back(8'h07);
      bus_start();
      write_byte(8'h84, a0);
      rw0 = rw;
      write_byte(8'h07, a1);
      bus_rstart();
      write_byte(8'h85, a2);
      checks += 5;
      if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL rs_acks: got %b, required 111", {a0, a1, a2}); end
      if (rw0 !== 1'b0 || rw !== 1'b1) begin
         failures++;
         $display("FAIL rs_rw: got %b->%b, required 0->1", rw0, rw);
      end
      read_byte(1'b0, d0);
      if (d0 !== 8'h99) begin failures++; $display("FAIL rs_read: got %h, required 99", d0); end
      if (n_start - st0 != 2) begin failures++; $display("FAIL rs_start_det: got %0d, required 2", n_start - st0); end
      if (n_rx - rx0 != 1 || n_tx - tx0 != 1) begin
         failures++;
         $display("FAIL rs_rx_tx: got %0d/%0d, required 1/1", n_rx - rx0, n_tx - tx0);
      end
      bus_stop();
   endtask

   task automatic test_glitch();
      int st0, sp0;
      st0 = n_start; sp0 = n_stop;
      wait_clk(Q);
      sda_drv = 1'b0;
      wait_clk(1);
      sda_drv = 1'b1;
      wait_clk(Q);
      sda_drv = 1'b0;
      wait_clk(2);
      sda_drv = 1'b1;
      wait_clk(2 * Q);
      checks++;
      if (n_start != st0 || n_stop != sp0) begin
         failures++;
         $display("FAIL glitch_det: got start=%0d stop=%0d, required 0 0", n_start - st0, n_stop - sp0);
      end
   endtask

   task automatic test_reset_mid();
      logic s, a0, a1;
      logic [7:0] addr;
      addr = 8'h84;
      bus_start();
      for (int i = 7; i >= 0; i--) bit_xfer(addr[i], s);
      wait_clk(Q);
      checks += 3;
      if (sda_oe !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_pre: got oe=%b busy=%b, required 1 1", sda_oe, busy);
      end
      rst_n = 1'b0;
      #1;
      if (sda_oe !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_async: got oe=%b busy=%b, required 0 0", sda_oe, busy);
      end
      scl_drv = 1'b1;
      sda_drv = 1'b1;
      wait_clk(2 * Q);
      rst_n = 1'b1;
      wait_clk(2 * Q);
      exp_rx_q.push_back(8'h5A);
      bus_start();
      write_byte(8'h84, a0);
      write_byte(8'h5A, a1);
      bus_stop();
      if ({a0, a1} !== 2'b11 || rx_data !== 8'h5A) begin
         failures++;
         $display("FAIL rstmid_after: got acks=%b rx_data=%h, required 11 5a", {a0, a1}, rx_data);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_addr_miss();
      test_backpressure();
      test_back_to_back();
      test_glitch();
      test_reset_mid();
      wait_clk(Q);
      checks++;
      if (exp_rx_q.size() != 0) begin
         failures++;
         $display("FAIL rx_scoreboard_drain: got %0d pending, required 0", exp_rx_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
